// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One command in flight at a time; reads return one cycle after the RAM's registered data.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a request; arbitration happens on the next edge
// ST_ISSUE  | ram_en high for one cycle; RAM performs the op at the edge ending it
// ST_RDWAIT | RAM read data valid; captured into the winner's rdata
module ram_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [4:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [4:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic [7:0] b_rdata,
  output logic       ram_en,
  output logic       ram_wr_rd,
  output logic [4:0] ram_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout,
  output logic       ram_rst,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  logic [1:0] r_state;
  logic       r_last_b;
  logic       r_owner_b;
  logic       r_a_gnt;
  logic       r_b_gnt;
  logic       r_a_rvalid;
  logic       r_b_rvalid;
  logic [7:0] r_a_rdata;
  logic [7:0] r_b_rdata;
  logic       r_ram_en;
  logic       r_ram_wr_rd;
  logic [4:0] r_ram_addr;
  logic [7:0] r_ram_din;

  logic w_any_req;
  logic w_pick_b;

  assign w_any_req = a_req | b_req;
  // B wins when it is alone, or when both ask and A was granted last
  assign w_pick_b  = b_req & (~a_req | ~r_last_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_last_b    <= 1'b1;
      r_owner_b   <= 1'b0;
      r_a_gnt     <= 1'b0;
      r_b_gnt     <= 1'b0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_a_rdata   <= 8'h00;
      r_b_rdata   <= 8'h00;
      r_ram_en    <= 1'b0;
      r_ram_wr_rd <= 1'b0;
      r_ram_addr  <= 5'd0;
      r_ram_din   <= 8'h00;
    end else begin
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state     <= ST_ISSUE;
            r_ram_en    <= 1'b1;
            r_owner_b   <= w_pick_b;
            r_last_b    <= w_pick_b;
            r_a_gnt     <= ~w_pick_b;
            r_b_gnt     <= w_pick_b;
            r_ram_wr_rd <= w_pick_b ? b_we    : a_we;
            r_ram_addr  <= w_pick_b ? b_addr  : a_addr;
            r_ram_din   <= w_pick_b ? b_wdata : a_wdata;
          end
        end
        ST_ISSUE: begin
          r_ram_en <= 1'b0;
          r_state  <= r_ram_wr_rd ? ST_IDLE : ST_RDWAIT;
        end
        ST_RDWAIT: begin
          if (r_owner_b) begin
            r_b_rdata  <= ram_dout;
            r_b_rvalid <= 1'b1;
          end else begin
            r_a_rdata  <= ram_dout;
            r_a_rvalid <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_ram_en <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_gnt     = r_a_gnt;
  assign b_gnt     = r_b_gnt;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign ram_en    = r_ram_en;
  assign ram_wr_rd = r_ram_wr_rd;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  // RAM contents are never cleared by this block
  assign ram_rst   = 1'b1;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: transaction-level model predicts grant order and read data,
// a negedge monitor pops expectations whenever the DUT grants or returns read data.
module tb_ram_arbiter;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic       who_b;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rexp;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       a_req, a_we, a_gnt, a_rvalid;
  logic [4:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_rvalid;
  logic [4:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic       ram_en, ram_wr_rd, ram_rst, busy;
  logic [4:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int vectors = 0;
  int miscompares = 0;

  exp_t gq[$];
  cmd_t qa[$];
  cmd_t qb[$];
  logic [7:0] m_mem [32];
  logic       m_last_b;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_rst(ram_rst), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM with registered read data; preloaded once, never cleared
  logic [7:0] ram_mem [32];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= 8'(i * 37 + 11);
      ram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_wr_rd) ram_mem[ram_addr] <= ram_din;
      else           ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor / scoreboard
  logic [7:0] m_a_rdata, m_b_rdata;
  bit         rd_pend, rd_b, post_chk, post_busy;
  int         rd_cnt;
  logic [7:0] rd_exp;

  initial begin
    exp_t e;
    bit due;
    rd_pend = 0; post_chk = 0; m_a_rdata = 8'h00; m_b_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rd_pend = 0; post_chk = 0; m_a_rdata = 8'h00; m_b_rdata = 8'h00;
      end else begin
        due = 0;
        if (rd_pend) begin
          rd_cnt--;
          if (rd_cnt == 0) begin due = 1; rd_pend = 0; end
        end
        if (due) begin
          chk("rvalid_a", 32'(a_rvalid), 32'(!rd_b));
          chk("rvalid_b", 32'(b_rvalid), 32'(rd_b));
          if (rd_b) m_b_rdata = rd_exp;
          else      m_a_rdata = rd_exp;
        end else if (a_rvalid || b_rvalid) begin
          flag("unexpected_rvalid");
        end
        chk("a_rdata", 32'(a_rdata), 32'(m_a_rdata));
        chk("b_rdata", 32'(b_rdata), 32'(m_b_rdata));
        if (post_chk) begin
          chk("busy_after_issue", 32'(busy), 32'(post_busy));
          chk("ram_en_one_cycle", 32'(ram_en), 32'd0);
          post_chk = 0;
        end
        if (a_gnt || b_gnt) begin
          chk("gnt_exclusive", 32'(a_gnt & b_gnt), 32'd0);
          if (gq.size() == 0) begin
            flag("unexpected_grant");
          end else begin
            e = gq.pop_front();
            chk("gnt_who", 32'(b_gnt), 32'(e.who_b));
            chk("issue_ram_en", 32'(ram_en), 32'd1);
            chk("issue_wr_rd", 32'(ram_wr_rd), 32'(e.we));
            chk("issue_addr", 32'(ram_addr), 32'(e.addr));
            chk("issue_din", 32'(ram_din), 32'(e.wdata));
            chk("issue_busy", 32'(busy), 32'd1);
            post_chk  = 1;
            post_busy = !e.we;
            if (!e.we) begin
              rd_pend = 1; rd_cnt = 2; rd_b = e.who_b; rd_exp = e.rexp;
            end
          end
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_ram_en"},    32'(ram_en),    32'd0);
    chk({tag, "_ram_wr_rd"}, 32'(ram_wr_rd), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_gnt"},       32'({a_gnt, b_gnt}), 32'd0);
    chk({tag, "_rvalid"},    32'({a_rvalid, b_rvalid}), 32'd0);
    chk({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    chk({tag, "_ram_din"},   32'(ram_din),   32'd0);
    chk({tag, "_a_rdata"},   32'(a_rdata),   32'd0);
    chk({tag, "_b_rdata"},   32'(b_rdata),   32'd0);
    chk({tag, "_ram_rst"},   32'(ram_rst),   32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_checks("reset");
    gq.delete();
    m_last_b = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic mk_cmd(output cmd_t c);
    int unsigned r;
    r = $urandom_range(0, 9);
    c.we    = 1'($urandom_range(0, 1));
    c.addr  = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(0, 31));
    c.wdata = 8'($urandom_range(0, 255));
  endtask

  // Model: predict grant order and read data for a round, then drive it
  task automatic run_round(input int na, input int nb, input bit b_late);
    int   ia, ib, cyc;
    bit   pb, first, b_started;
    cmd_t c;
    exp_t e;
    ia = 0; ib = 0; first = 1;
    while (ia < na || ib < nb) begin
      if (b_late && first)      pb = 1'b0;
      else if (ia < na && ib < nb) pb = !m_last_b;
      else                      pb = (ib < nb);
      if (pb) begin c = qb[ib]; ib++; end
      else    begin c = qa[ia]; ia++; end
      e.who_b = pb; e.we = c.we; e.addr = c.addr; e.wdata = c.wdata;
      e.rexp  = c.we ? 8'h00 : m_mem[c.addr];
      if (c.we) m_mem[c.addr] = c.wdata;
      gq.push_back(e);
      m_last_b = pb;
      first = 0;
    end

    ia = 0; ib = 0; cyc = 0; b_started = 0;
    if (na > 0) begin
      a_req = 1'b1; a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata;
    end
    if (nb > 0 && !b_late) begin
      b_req = 1'b1; b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata;
      b_started = 1;
    end
    while ((ia < na || ib < nb) && cyc < 60) begin
      @(posedge clk);
      #1 cyc++;
      if (a_gnt) begin
        ia++;
        if (ia < na) begin a_we = qa[ia].we; a_addr = qa[ia].addr; a_wdata = qa[ia].wdata; end
        else a_req = 1'b0;
        if (!b_started && nb > 0) begin
          b_req = 1'b1; b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata;
          b_started = 1;
        end
      end
      if (b_gnt) begin
        ib++;
        if (ib < nb) begin b_we = qb[ib].we; b_addr = qb[ib].addr; b_wdata = qb[ib].wdata; end
        else b_req = 1'b0;
      end
    end
    if (ia < na || ib < nb) begin
      flag("round_timeout");
      a_req = 1'b0; b_req = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1 chk("queue_drained", 32'(gq.size()), 32'd0);
    gq.delete();
    qa.delete();
    qb.delete();
  endtask

  task automatic reset_mid_read();
    exp_t e;
    int   cyc;
    e.who_b = 1'b0; e.we = 1'b0; e.addr = 5'd17; e.wdata = 8'h3C; e.rexp = m_mem[17];
    gq.push_back(e);
    m_last_b = 1'b0;
    a_we = 1'b0; a_addr = 5'd17; a_wdata = 8'h3C; a_req = 1'b1;
    cyc = 0;
    while (!a_gnt && cyc < 20) begin @(posedge clk); #1 cyc++; end
    if (!a_gnt) flag("mid_read_gnt_timeout");
    a_req = 1'b0;
    @(posedge clk);
    #2 chk("rdwait_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1 reset_checks("mid_read");
    repeat (2) @(posedge clk);
    gq.delete();
    m_last_b = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    cmd_t c;
    int   na, nb;
    bit   bl;
    rst = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 5'd0; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 5'd0; b_wdata = 8'h00;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'(i * 37 + 11);
    m_last_b = 1'b1;
    do_reset();

    qa.push_back('{we: 1'b1, addr: 5'd3, wdata: 8'hA5});
    run_round(1, 0, 1'b0);
    qb.push_back('{we: 1'b0, addr: 5'd3, wdata: 8'h00});
    run_round(0, 1, 1'b0);

    do_reset();
    for (int i = 0; i < 2; i++) begin
      mk_cmd(c); c.we = 1'b1; qa.push_back(c);
      mk_cmd(c); c.we = 1'b1; qb.push_back(c);
    end
    run_round(2, 2, 1'b0);

    qa.push_back('{we: 1'b1, addr: 5'd31, wdata: 8'hFF});
    qa.push_back('{we: 1'b0, addr: 5'd31, wdata: 8'h00});
    qa.push_back('{we: 1'b0, addr: 5'd0,  wdata: 8'h00});
    run_round(3, 0, 1'b0);

    reset_mid_read();
    qa.push_back('{we: 1'b0, addr: 5'd31, wdata: 8'h11});
    qb.push_back('{we: 1'b0, addr: 5'd3,  wdata: 8'h22});
    run_round(1, 1, 1'b0);

    qa.push_back('{we: 1'b1, addr: 5'd9, wdata: 8'h5A});
    qb.push_back('{we: 1'b1, addr: 5'd9, wdata: 8'hC3});
    qb.push_back('{we: 1'b0, addr: 5'd9, wdata: 8'h00});
    run_round(1, 2, 1'b1);

    for (int r = 0; r < 40; r++) begin
      na = int'($urandom_range(0, 3));
      nb = int'($urandom_range(0, 3));
      if (na == 0 && nb == 0) na = 1;
      bl = (na > 0 && nb > 0 && $urandom_range(0, 3) == 0);
      for (int i = 0; i < na; i++) begin mk_cmd(c); qa.push_back(c); end
      for (int i = 0; i < nb; i++) begin mk_cmd(c); qb.push_back(c); end
      run_round(na, nb, bl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); rst input 1 (asynchronous, active-low; 0 = reset).
REQ-002 a_req input 1: requester A command request; held high until a_gnt is seen.
REQ-003 a_we input 1: A operation; 1 = write, 0 = read; stable while a_req is high.
REQ-004 a_addr input 5: A word address (0-31); stable while a_req is high.
REQ-005 a_wdata input 8: A write data; stable while a_req is high.
REQ-006 a_gnt output 1: one-cycle pulse; A command accepted.
REQ-007 a_rvalid output 1: one-cycle pulse; a_rdata valid.
REQ-008 a_rdata output 8: A read data; holds its value until the next A read completes.
REQ-009 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata SHALL mirror REQ-002..008 for requester B.
REQ-010 ram_en output 1: RAM enable.
REQ-011 ram_wr_rd output 1: RAM operation; 1 = write, 0 = read.
REQ-012 ram_addr output 5: RAM address.
REQ-013 ram_din output 8: RAM write data.
REQ-014 ram_dout input 8: RAM registered read data; valid one cycle after the read edge.
REQ-015 ram_rst output 1: RAM synchronous clear, active-low; driven 1 constantly. The block never clears RAM contents.
REQ-016 busy output 1: 1 whenever the state is not IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, RDWAIT.
REQ-018 In IDLE with no request, the state SHALL remain IDLE and ram_en SHALL stay 0.
REQ-019 IDLE to ISSUE at the edge where any req is sampled high. At that edge:
- winner's gnt registered high for exactly one cycle;
- winner's we/addr/wdata latched into ram_wr_rd/ram_addr/ram_din;
- ram_en set to 1.
REQ-020 Arbitration SHALL be round-robin:
- single requester: that requester wins;
- both requesting: the requester not granted last wins.
REQ-021 The last-grant pointer SHALL reset to B, so A wins the first contention.
REQ-022 In ISSUE, ram_en=1 for exactly one cycle. Outputs are registered, so the RAM performs the operation at the edge that ends ISSUE.
REQ-023 From ISSUE, a write SHALL return to IDLE and a read SHALL go to RDWAIT. ram_en returns to 0 at that edge.
REQ-024 In RDWAIT, at the edge ending the cycle:
- ram_dout captured into the winner's rdata;
- winner's rvalid set for one cycle;
- state returns to IDLE.
REQ-025 Latency from the req-sampling edge:
- gnt in cycle +1;
- write committed at edge +2;
- read rvalid/rdata in cycle +3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
REQ-026 Requests arriving while busy=1 SHALL be ignored until IDLE and SHALL not be lost while req stays high.
REQ-027 A requester that keeps req high after its gnt SHALL be treated as a new request. Under contention, round-robin then alternates grants strictly.
REQ-028 a_gnt and b_gnt SHALL never be high in the same cycle. Likewise a_rvalid and b_rvalid.
REQ-029 Only the granted requester's rdata SHALL change on read completion. The other requester's rdata holds.
REQ-030 Address 31 and address 0 SHALL need no special handling (no wrap logic; 5-bit address).

Reset
REQ-031 While rst=0, regardless of clk:
- state=IDLE;
- ram_en, ram_wr_rd, busy, a_gnt, b_gnt, a_rvalid, b_rvalid = 0;
- ram_addr, ram_din, a_rdata, b_rdata = 0;
- last-grant pointer = B.
REQ-032 Reset asserted during ISSUE or RDWAIT SHALL abort the operation:
- no rvalid is issued afterward;
- the aborted requester must re-request.
REQ-033 The first request SHALL be sampled at the first rising edge with rst=1.

Verification
REQ-034 Single write: A writes 8'hA5 to addr 3. Required: a_gnt in cycle 1; ram_en=1, ram_wr_rd=1, ram_addr=3, ram_din=A5 in cycle 1; busy=0 in cycle 2.
REQ-035 Single read: B reads addr 3 after REQ-034. Required: b_gnt in cycle 1; b_rvalid=1 with b_rdata=8'hA5 in cycle 3; a_rdata unchanged.
REQ-036 Contention: A and B request together from reset and hold req high for 4 grants. Required grant order A, B, A, B; never two gnts in one cycle.
REQ-037 Boundary: A writes 8'hFF to addr 31, then reads addr 31 back. Required: a_rdata=8'hFF; addr 0 contents unchanged.
REQ-038 Reset mid-read: rst=0 during RDWAIT. Required: all outputs at reset values immediately (asynchronous); no rvalid after release; next grant goes to A.
REQ-039 Request while busy: B raises req during A's ISSUE cycle. Required: B granted in the first IDLE cycle after A completes; B's command is executed intact.
